// File: rtl/hrm_outbox_uart_tx.sv
// Drains the hrmcpu OUTBOX show-ahead FIFO and serialises each byte as 8N1 UART on tx.
// Define HRM_OUTBOX_HEX_ASCII_EN to send each byte as two hex ASCII digits plus a line feed.
module hrm_outbox_uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       out_empty,
  input  logic [7:0] out_data,
  output logic       out_rd,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_cnt, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_d;
  logic          bit_end;

`ifdef HRM_OUTBOX_HEX_ASCII_EN
  logic [7:0] byte_r, byte_d;
  logic [1:0] frame_idx, frame_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign busy    = (state != IDLE) || out_rd;

  always_comb begin
    state_d  = state;
    baud_d   = baud_cnt;
    bit_d    = bit_cnt;
    shreg_d  = shreg;
    out_rd   = 1'b0;
`ifdef HRM_OUTBOX_HEX_ASCII_EN
    byte_d   = byte_r;
    frame_d  = frame_idx;
`endif
    case (state)
      IDLE: begin
        baud_d = '0;
        // Gating with i_rst keeps a pop from being signalled while reset holds the FSM
        if (!out_empty && !i_rst) begin
          out_rd  = 1'b1;
          bit_d   = 3'd0;
          state_d = START;
`ifdef HRM_OUTBOX_HEX_ASCII_EN
          byte_d  = out_data;
          frame_d = 2'd0;
          shreg_d = hex_ascii(out_data[7:4]);
`else
          shreg_d = out_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_cnt == 3'd7) begin
            state_d = STOP;
          end else begin
            shreg_d = {1'b0, shreg[7:1]};
            bit_d   = bit_cnt + 3'd1;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
`ifdef HRM_OUTBOX_HEX_ASCII_EN
          // Chain the low digit and line feed straight into START with no idle gap
          if (frame_idx == 2'd2) begin
            state_d = IDLE;
          end else begin
            frame_d = frame_idx + 2'd1;
            shreg_d = (frame_idx == 2'd0) ? hex_ascii(byte_r[3:0]) : 8'h0A;
            bit_d   = 3'd0;
            state_d = START;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next-state view so the pin never glitches
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
`ifdef HRM_OUTBOX_HEX_ASCII_EN
      byte_r    <= '0;
      frame_idx <= '0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shreg    <= shreg_d;
      tx       <= tx_d;
`ifdef HRM_OUTBOX_HEX_ASCII_EN
      byte_r    <= byte_d;
      frame_idx <= frame_d;
`endif
    end
  end

endmodule

// File: tb/tb_hrm_outbox_uart_tx.sv
// Directed bench for hrm_outbox_uart_tx with CLKS_PER_BIT=4 and a show-ahead FIFO model.
// The hex ASCII scenario runs only when HRM_OUTBOX_HEX_ASCII_EN is defined.
module tb_hrm_outbox_uart_tx;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       out_empty;
  logic [7:0] out_data;
  logic       out_rd;
  logic       tx;
  logic       busy;

  logic [7:0] fifo[$];
  logic       tx_q[$];
  logic       rd_q[$];
  logic       busy_q[$];
  logic       rd_pending;
  int         checks = 0;
  int         failures = 0;

  hrm_outbox_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .i_rst(i_rst), .out_empty(out_empty), .out_data(out_data),
    .out_rd(out_rd), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic updateInputs();
    out_empty = (fifo.size() == 0);
    out_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo.push_back(b);
    updateInputs();
  endtask

  // One clock: sample outputs on the falling edge, retire a pop just after the rising edge
  task automatic tick();
    @(negedge clk);
    tx_q.push_back(tx);
    rd_q.push_back(out_rd);
    busy_q.push_back(busy);
    rd_pending = out_rd;
    @(posedge clk);
    #1;
    if (rd_pending && fifo.size() != 0) void'(fifo.pop_front());
    updateInputs();
  endtask

  task automatic clearTrace();
    tx_q.delete();
    rd_q.delete();
    busy_q.delete();
  endtask

  function automatic int countRd();
    int n = 0;
    foreach (rd_q[i]) if (rd_q[i]) n++;
    return n;
  endfunction

  function automatic int countBusy(input int upto);
    int n = 0;
    for (int i = 0; i < upto && i < busy_q.size(); i++) if (busy_q[i]) n++;
    return n;
  endfunction

  function automatic int countTxLow();
    int n = 0;
    foreach (tx_q[i]) if (!tx_q[i]) n++;
    return n;
  endfunction

  function automatic int nthPop(input int k);
    int seen = 0;
    foreach (rd_q[i]) begin
      if (rd_q[i]) begin
        if (seen == k) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  // s is the first cycle of the start bit; each data bit is sampled one cycle into its slot
  function automatic logic [7:0] decodeAt(input int s);
    logic [7:0] b;
    b = 8'hxx;
    if (s >= 0 && s + 37 < tx_q.size()) begin
      for (int i = 0; i < 8; i++) b[i] = tx_q[s + 4 * (i + 1) + 1];
    end
    return b;
  endfunction

  function automatic logic [3:0] bitSlot(input int s);
    logic [3:0] v;
    v = 4'hx;
    if (s >= 0 && s + 3 < tx_q.size()) v = {tx_q[s], tx_q[s+1], tx_q[s+2], tx_q[s+3]};
    return v;
  endfunction

  initial begin
    logic [9:0] frame23;
    frame23 = 10'b1_00100011_0;
    i_rst     = 1'b0;
    out_empty = 1'b1;
    out_data  = 8'h00;

    // Test 1: asynchronous reset before any clock edge
    #3 i_rst = 1'b1;
    #1;
    checkOutput("t1_tx", {31'd0, tx}, 32'd1);
    checkOutput("t1_rd", {31'd0, out_rd}, 32'd0);
    checkOutput("t1_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #3 i_rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t1_tx_after", {31'd0, tx}, 32'd1);
    checkOutput("t1_busy_after", {31'd0, busy}, 32'd0);

    // Test 2: single byte 0x23
    clearTrace();
    applyStimulus(8'h23);
    repeat (45) tick();
    checkOutput("t2_pop_cycle", {31'd0, rd_q[0]}, 32'd1);
    checkOutput("t2_pop_count", countRd(), 32'd1);
    checkOutput("t2_tx_idle", {31'd0, tx_q[0]}, 32'd1);
    for (int b = 0; b < 10; b++)
      checkOutput($sformatf("t2_bit%0d", b), {28'd0, bitSlot(1 + 4 * b)}, {28'd0, {4{frame23[b]}}});
    checkOutput("t2_busy_cycles", countBusy(45), 32'd41);
    checkOutput("t2_busy_first", {31'd0, busy_q[0]}, 32'd1);
    checkOutput("t2_busy_drop", {31'd0, busy_q[41]}, 32'd0);
    checkOutput("t2_tx_after", {31'd0, tx_q[41]}, 32'd1);

    // Test 3: three bytes back-to-back
    clearTrace();
    applyStimulus(8'h15);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (133) tick();
    checkOutput("t3_pop_count", countRd(), 32'd3);
    checkOutput("t3_pop0", nthPop(0), 32'd0);
    checkOutput("t3_pop1", nthPop(1), 32'd41);
    checkOutput("t3_pop2", nthPop(2), 32'd82);
    checkOutput("t3_gap_tx", {31'd0, tx_q[41]}, 32'd1);
    checkOutput("t3_start1", {31'd0, tx_q[42]}, 32'd0);
    checkOutput("t3_byte0", {24'd0, decodeAt(1)}, 32'h15);
    checkOutput("t3_byte1", {24'd0, decodeAt(42)}, 32'h11);
    checkOutput("t3_byte2", {24'd0, decodeAt(83)}, 32'h22);
    checkOutput("t3_stop2", {31'd0, tx_q[83 + 37]}, 32'd1);

    // Test 4: reset during data bit 3 of 0xA5
    clearTrace();
    applyStimulus(8'hA5);
    repeat (19) tick();
    checkOutput("t4_pre_tx", {31'd0, tx}, 32'd0);
    checkOutput("t4_pre_busy", {31'd0, busy}, 32'd1);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("t4_rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("t4_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("t4_rst_rd", {31'd0, out_rd}, 32'd0);
    #10 i_rst = 1'b0;
    @(posedge clk);
    #1;
    clearTrace();
    repeat (60) tick();
    checkOutput("t4_tx_low", countTxLow(), 32'd0);
    checkOutput("t4_pops", countRd(), 32'd0);
    checkOutput("t4_busy", countBusy(60), 32'd0);

    // Test 5: empty FIFO for 200 cycles
    clearTrace();
    repeat (200) tick();
    checkOutput("t5_tx_low", countTxLow(), 32'd0);
    checkOutput("t5_pops", countRd(), 32'd0);
    checkOutput("t5_busy", countBusy(200), 32'd0);

`ifdef HRM_OUTBOX_HEX_ASCII_EN
    // Test 6: 0x3F as "3", "F", LF; a second byte arrives mid-sequence
    clearTrace();
    applyStimulus(8'h3F);
    for (int t = 0; t < 130; t++) begin
      if (t == 60) applyStimulus(8'h41);
      tick();
    end
    checkOutput("t6_pop0", nthPop(0), 32'd0);
    checkOutput("t6_pop1", nthPop(1), 32'd121);
    checkOutput("t6_pop_count", countRd(), 32'd2);
    checkOutput("t6_busy_cycles", countBusy(121), 32'd121);
    checkOutput("t6_frame0", {24'd0, decodeAt(1)}, 32'h33);
    checkOutput("t6_frame1", {24'd0, decodeAt(41)}, 32'h46);
    checkOutput("t6_frame2", {24'd0, decodeAt(81)}, 32'h0A);
    checkOutput("t6_stop0", {31'd0, tx_q[40]}, 32'd1);
    checkOutput("t6_final_stop", {31'd0, tx_q[120]}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
